logic16_arbiter: RTL and testbench
==================================

// Module: logic16_arbiter
// PURPOSE
//  Shares one 16-bit bitwise logic unit (AND16/OR16/XOR16/NOT16) between NREQ requesters.
//  Round-robin arbitration, valid/ready handshake on both request and response sides.
//  Each transaction returns a registered result tagged with the requester index.
//  Sits between CPU-side clients and the shared gate-level logic datapath.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  WIDTH  16  operand/result width in bits
//  IDW    2   width of resp_id; must equal clog2(NREQ)
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           synchronous, active-high reset
//  req_valid   in   NREQ        request valid, one bit per requester
//  req_ready   out  NREQ        request accepted this cycle (one-hot or zero)
//  req_a       in   NREQ*WIDTH  operand a; requester i at [i*WIDTH +: WIDTH]
//  req_b       in   NREQ*WIDTH  operand b, same packing (ignored for NOT)
//  req_op      in   NREQ*2      opcode; requester i at [i*2 +: 2]
//  resp_valid  out  1           result valid
//  resp_ready  in   1           consumer accepts result
//  resp_out    out  WIDTH       result
//  resp_id     out  IDW         index of the requester that owns resp_out
//  busy        out  1           high in any state other than IDLE
// BEHAVIOUR
//  Opcodes: 00 out=a&b; 01 out=a|b; 10 out=a^b; 11 out=~a.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: if any req_valid, winner = first set bit scanning from ptr+1 upward, wrapping mod NREQ.
//     req_ready[winner]=1 combinationally in that cycle; at the edge, latch a/b/op/id and ptr<=winner.
//     Go to EXEC. With no req_valid: stay in IDLE, req_ready=0.
//   EXEC: evaluate op on latched operands; at the edge, register resp_out/resp_id, set resp_valid, go to RESP.
//   RESP: hold resp_valid/resp_out/resp_id stable until resp_ready=1.
//     On that edge: clear resp_valid, go to IDLE.
//  req_ready is 0 in EXEC and RESP, and during reset.
//  No new request is accepted in the cycle the response handshakes (no bypass).
//  Latency: accept edge to resp_valid high = 2 clocks. Max throughput: 1 transaction per 3 clocks.
//  Fairness: a continuously asserted requester is served within NREQ transactions.
//  Requesters hold valid/operands until ready. A dropped valid before accept is not an error.
//   Arbitration is re-evaluated every IDLE cycle.
//  Reset values: state=IDLE, ptr=NREQ-1 (requester 0 has first priority), resp_valid=0,
//   resp_out=0, resp_id=0, busy=0, req_ready=0.
//  Reset mid-transaction: the in-flight operation is discarded, no response is issued,
//   and reset values apply on the next edge.
//  resp_out/resp_id keep their last value after the handshake. They are only meaningful while resp_valid=1.
// TESTING
//  1. Req0 only, op=01, a=CCCC, b=AAAA, resp_ready=1
//     -> req_ready[0] in accept cycle; 2 clk later resp_valid=1, resp_out=EEEE, resp_id=0.
//  2. All four ops on req1, a=F0F0, b=FF00
//     -> AND=F000, OR=FFF0, XOR=0FF0, NOT=0F0F, each resp_id=1.
//  3. All req_valid held high, resp_ready=1, 8 transactions
//     -> grant order 0,1,2,3,0,1,2,3; at most one req_ready bit set per cycle.
//  4. resp_ready=0 for 5 cycles after resp_valid
//     -> resp_valid/resp_out stay stable, req_ready=0 throughout; one transaction completes after release.
//  5. Assert reset during EXEC
//     -> no resp_valid ever for that op; next request from req0 wins first (ptr reset).
//  6. Only req2 and req3 valid, req2 served last
//     -> req3 granted next; after that, req2 granted.

Source files
------------

// File: rtl/logic16_arbiter.sv
// logic16_arbiter
//   Shares one bitwise logic unit (AND/OR/XOR/NOT) between NREQ requesters.
//   Round-robin grant, valid/ready on both sides, one transaction in flight.
//   Each response is registered and tagged with the requester index.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   req_valid   [NREQ]        per-requester request valid
//   req_ready   [NREQ]        one-hot grant, combinational, IDLE only
//   req_a/req_b [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   req_op      [NREQ*2]      opcode, requester i at [i*2 +: 2]
//   resp_valid/resp_ready     response handshake
//   resp_out    [WIDTH]       result, meaningful only while resp_valid
//   resp_id     [IDW]         owner of resp_out
//   busy                      high whenever a transaction is in flight

// One bit-slice of the shared logic unit.
//   op: 00 a&b, 01 a|b, 10 a^b, 11 ~a
module logic16_arbiter_cell (
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op,
  output logic       y
);
  assign y = op[1] ? (op[0] ? ~a : (a ^ b))
                   : (op[0] ? (a | b) : (a & b));
endmodule

module logic16_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_out,
  output logic [IDW-1:0]        resp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [IDW-1:0]   id;
  } txn_t;

  state_t   state;
  txn_t     cur;
  logic [IDW-1:0] ptr;

  // Per-requester views of the flat request buses.
  logic [NREQ-1:0][WIDTH-1:0] a_lane;
  logic [NREQ-1:0][WIDTH-1:0] b_lane;
  logic [NREQ-1:0][1:0]       op_lane;

  assign a_lane  = req_a;
  assign b_lane  = req_b;
  assign op_lane = req_op;

  // (p + k) mod NREQ, valid for non-power-of-two NREQ as well.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NREQ;
    return s[IDW-1:0];
  endfunction

  // Round-robin pick: first valid requester after ptr, wrapping.
  // Scan from the far end so the nearest candidate overwrites last.
  logic           grant_found;
  logic [IDW-1:0] grant_id;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[wrap_idx(ptr, k)]) begin
        grant_found = 1'b1;
        grant_id    = wrap_idx(ptr, k);
      end
    end
  end

  logic accept;
  assign accept = (state == IDLE) && !reset && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  // Shared logic unit, built from bit-slices on the latched operands.
  logic [WIDTH-1:0] alu_y;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    logic16_arbiter_cell u_cell (
      .a  (cur.a[g]),
      .b  (cur.b[g]),
      .op (cur.op),
      .y  (alu_y[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Any in-flight operation is dropped without a response.
      state      <= IDLE;
      ptr        <= IDW'(NREQ - 1);
      cur        <= '0;
      resp_valid <= 1'b0;
      resp_out   <= '0;
      resp_id    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            cur.a  <= a_lane[grant_id];
            cur.b  <= b_lane[grant_id];
            cur.op <= op_lane[grant_id];
            cur.id <= grant_id;
            ptr    <= grant_id;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          resp_out   <= alu_y;
          resp_id    <= cur.id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          // No bypass: IDLE always spends a cycle before the next grant.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic16_arbiter.sv
module tb_logic16_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*W-1:0]    req_a, req_b;
  logic [NREQ*2-1:0]    req_op;
  logic                 resp_valid, resp_ready;
  logic [W-1:0]         resp_out;
  logic [IDW-1:0]       resp_id;
  logic                 busy;

  logic16_arbiter #(.NREQ(NREQ), .WIDTH(W), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_out(resp_out), .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int           m_ptr, m_acc, m_cyc, m_id;
  bit           m_pend;
  logic [W-1:0] m_out;
  int           gnt_q[$];
  logic [W-1:0] done_out[$];
  int           done_id[$];

  function automatic int pick(int p, logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] lop(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Compare process: predict outputs each cycle, then advance the model
  // across the coming edge using the inputs the DUT will sample.
  initial begin : scoreboard
    logic [NREQ-1:0] er;
    int w;
    bit ev;
    m_ptr = NREQ - 1; m_pend = 0; m_cyc = 0; m_acc = 0; m_id = 0; m_out = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      w  = pick(m_ptr, req_valid);
      er = '0;
      if (!m_pend && !reset && w >= 0) er[w] = 1'b1;
      ev = m_pend && (m_cyc >= m_acc + 2);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(m_pend));
      if (ev) begin
        chk("resp_out", 32'(resp_out), 32'(m_out));
        chk("resp_id", 32'(resp_id), 32'(m_id));
      end
      if (reset) begin
        m_pend = 0;
        m_ptr  = NREQ - 1;
      end else if (!m_pend) begin
        if (w >= 0) begin
          m_pend = 1; m_acc = m_cyc; m_ptr = w; m_id = w;
          m_out  = lop(req_op[w*2 +: 2], req_a[w*W +: W], req_b[w*W +: W]);
          gnt_q.push_back(w);
        end
      end else if (ev && resp_ready) begin
        m_pend = 0;
        done_out.push_back(m_out);
        done_id.push_back(m_id);
      end
      m_cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic set_req(int i, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req_valid[i]     = 1'b1;
    req_op[i*2 +: 2] = op;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  task automatic wait_grant(int i);
    bit ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1; break; end
    end
    chk("grant_wait", 32'(ok), 32'd1);
    step();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp();
    bit ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin ok = 1; break; end
    end
    chk("resp_wait", 32'(ok), 32'd1);
    step();
  endtask

  task automatic wait_grants(int target);
    for (int c = 0; c < 100 && gnt_q.size() < target; c++) step();
    chk("grants_wait", 32'(gnt_q.size() >= target), 32'd1);
  endtask

  task automatic txn(int i, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    set_req(i, op, a, b);
    wait_grant(i);
    wait_resp();
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0]    t2_exp [4];
  logic [NREQ-1:0] g;
  int              n, nd;

  initial begin
    t2_exp = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0F0F};
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_out", 32'(resp_out), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    step();
    reset = 1'b0;
    resp_ready = 1'b1;

    // Single OR transaction from requester 0.
    txn(0, 2'b01, 16'hCCCC, 16'hAAAA);
    chk("t1_out", 32'(done_out[$]), 32'h0000EEEE);
    chk("t1_id", 32'(done_id[$]), 32'd0);

    // All four opcodes on requester 1.
    for (int op = 0; op < 4; op++) begin
      txn(1, 2'(op), 16'hF0F0, 16'hFF00);
      chk("t2_out", 32'(done_out[$]), 32'(t2_exp[op]));
      chk("t2_id", 32'(done_id[$]), 32'd1);
    end

    // All requesters held valid: round-robin order from reset.
    do_reset();
    n = gnt_q.size();
    for (int i = 0; i < NREQ; i++) set_req(i, 2'(i), 16'h1234 + 16'(i), 16'h0FF0);
    wait_grants(n + 8);
    req_valid = '0;
    wait_resp();
    for (int k = 0; k < 8; k++) chk("t3_order", 32'(gnt_q[n + k]), 32'(k % NREQ));

    // Consumer stalls 5 cycles with the response pending.
    nd = done_out.size();
    resp_ready = 1'b0;
    set_req(2, 2'b10, 16'hA5A5, 16'h0F0F);
    wait_grant(2);
    for (int c = 0; c < 10 && !resp_valid; c++) step();
    repeat (5) step();
    @(negedge clk);
    chk("t4_busy_hold", 32'(busy), 32'd1);
    chk("t4_no_done", 32'(done_out.size()), 32'(nd));
    step();
    resp_ready = 1'b1;
    wait_resp();
    chk("t4_done", 32'(done_out.size()), 32'(nd + 1));
    chk("t4_out", 32'(done_out[$]), 32'h0000AAAA);

    // Reset while the op is executing; pointer must restart.
    txn(2, 2'b00, 16'hFFFF, 16'h00FF);
    nd = done_out.size();
    set_req(2, 2'b01, 16'h1234, 16'h5678);
    wait_grant(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n = gnt_q.size();
    set_req(0, 2'b11, 16'h00FF, 16'h0000);
    set_req(3, 2'b00, 16'hFFFF, 16'hFFFF);
    wait_grants(n + 1);
    req_valid = '0;
    wait_resp();
    chk("t5_first", 32'(gnt_q[n]), 32'd0);
    chk("t5_done", 32'(done_out.size()), 32'(nd + 1));
    chk("t5_out", 32'(done_out[$]), 32'h0000FF00);

    // Requester 2 served last: 3 wins before 2.
    txn(2, 2'b10, 16'h0001, 16'h0003);
    n = gnt_q.size();
    set_req(2, 2'b00, 16'hFFFF, 16'h8001);
    set_req(3, 2'b01, 16'h1000, 16'h0001);
    wait_grants(n + 2);
    req_valid = '0;
    wait_resp();
    chk("t6_first", 32'(gnt_q[n]), 32'd3);
    chk("t6_second", 32'(gnt_q[n + 1]), 32'd2);

    // Randomized traffic with occasional resets; model checks every cycle.
    g = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && g[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 249) == 0);
      @(negedge clk);
      g = req_ready;
      step();
    end
    reset = 1'b0; req_valid = '0; resp_ready = 1'b1;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
